round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTS, default 8, the number of requesters (legal range 2..32).
REQ-002 SHALL have derived parameter INDEX_WIDTH, default clog2(NUM_REQUESTS), the width of the grant index.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state is rising-edge clocked.
REQ-004 SHALL have port reset_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port request_in, input, NUM_REQUESTS, one request bit per requester.
REQ-006 SHALL have port grant_ready_in, input, 1, downstream accepts the presented grant.
REQ-007 SHALL have port grant_valid_out, output, 1, a grant is presented.
REQ-008 SHALL have port grant_onehot_out, output, NUM_REQUESTS, the one-hot granted requester.
REQ-009 SHALL have port grant_index_out, output, INDEX_WIDTH, the binary index of the granted requester.
REQ-010 SHALL have port lock_in, input, 1, keep the current grant owner across acceptance (present only under ARB_GRANT_LOCK_EN).

Function
REQ-011 SHALL implement two states: IDLE (no grant presented) and GRANT (grant presented, waiting for acceptance).
REQ-012 In IDLE with request_in nonzero, SHALL register a winner and enter GRANT on the next edge; latency from request to grant_valid_out is 1 cycle.
REQ-013 SHALL choose the winner as the first set request_in bit searching upward from priority pointer P, wrapping from NUM_REQUESTS-1 to 0.
REQ-014 In GRANT, SHALL hold grant_valid_out, grant_onehot_out and grant_index_out stable until grant_valid_out and grant_ready_in are both high (acceptance), even if the granted request bit drops.
REQ-015 On acceptance, SHALL set P to (granted index + 1) mod NUM_REQUESTS; the wrap at NUM_REQUESTS-1 gives P = 0.
REQ-016 On an acceptance edge, SHALL arbitrate the same cycle's request_in using the updated P.
REQ-017 On an acceptance edge, if any request remains, SHALL stay in GRANT with the new winner, sustaining one grant per cycle; otherwise SHALL go to IDLE.
REQ-018 The just-accepted requester SHALL be eligible again only after all other active requesters, as a consequence of the P update.
REQ-019 In IDLE, grant_onehot_out and grant_index_out SHALL be 0.
REQ-020 grant_onehot_out SHALL never have more than one bit set.
REQ-021 grant_index_out SHALL always encode grant_onehot_out.
REQ-022 grant_ready_in SHALL be ignored while grant_valid_out is low.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting reset_n_in low SHALL immediately, without waiting for a clock, force state IDLE, P = 0, grant_valid_out = 0, grant_onehot_out = 0 and grant_index_out = 0.
REQ-025 Reset asserted while in GRANT SHALL drop the pending grant without an acceptance and without updating P beyond the reset value.
REQ-026 The first arbitration after reset deassertion SHALL start from index 0.

Configuration
REQ-027 The ARB_GRANT_LOCK_EN macro SHALL control grant locking.
REQ-028 With ARB_GRANT_LOCK_EN defined, if lock_in is high at acceptance and the owner's request bit is still set, SHALL keep P unchanged and re-grant the same index next cycle (burst ownership).
REQ-029 With ARB_GRANT_LOCK_EN defined, if lock_in is high but the owner's request bit is clear, SHALL behave as REQ-015/REQ-016.
REQ-030 Without ARB_GRANT_LOCK_EN, SHALL omit the lock_in port and lock logic, and behaviour SHALL be exactly REQ-011..REQ-023.

Structure
REQ-031 The shared arbiter package SHALL hold the IDLE/GRANT state encoding and the clog2 constant function.
REQ-032 The design SHALL use one sub-module, rr_priority_encoder: combinational rotate-by-P, find-first-one and un-rotate, producing a one-hot winner, a binary index and an any-request flag.
REQ-033 The FSM, pointer and output registers SHALL live in round_robin_arbiter.

Verification (NUM_REQUESTS=4)
REQ-034 With reset released and request_in=4'b1010 held, grant_ready_in=1 -> grant indices 1,3,1,3 on consecutive cycles starting 1 cycle after request.
REQ-035 With request_in=4'b1111 and grant_ready_in=1 -> grant indices 0,1,2,3,0 (wrap verified).
REQ-036 With request_in=4'b0100 and grant_ready_in=0 for 5 cycles, and the request dropped on cycle 2 -> grant_index_out=2 and grant_onehot_out=4'b0100 held all 5 cycles; on grant_ready_in=1 -> IDLE next cycle.
REQ-037 With reset_n_in pulsed low mid-GRANT (index 3 pending) -> outputs 0 without a clock edge; with 4'b1001 requested after release -> grant index 0 first.
REQ-038 With ARB_GRANT_LOCK_EN defined, request_in=4'b0011 and lock_in=1 for 3 acceptances -> indices 0,0,0,0; with lock_in=0 -> index 1 next.
REQ-039 Without ARB_GRANT_LOCK_EN, a one-hot and index-consistency check SHALL run every cycle under random request_in/grant_ready_in for 10k cycles, with no requester starved for more than NUM_REQUESTS acceptances.

Source files
------------

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and a
// constant clog2 used to size the grant index.
package round_robin_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2 for elaboration-time sizing; returns at least 1 so a
  // two-requester arbiter still gets a one-bit index.
  function automatic int arb_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_priority_encoder.sv
// Combinational round-robin search: rotate requests so the pointer sits at
// bit 0, find the lowest set bit, then map the position back to a real index.
module rr_priority_encoder
  import round_robin_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTS = 8,
  parameter int INDEX_WIDTH  = arb_clog2(NUM_REQUESTS)
) (
  input  logic [NUM_REQUESTS-1:0] request_in,
  input  logic [INDEX_WIDTH-1:0]  pointer_in,
  output logic [NUM_REQUESTS-1:0] winner_onehot_out,
  output logic [INDEX_WIDTH-1:0]  winner_index_out,
  output logic                    any_request_out
);

  localparam logic [INDEX_WIDTH:0] NUM_W = (INDEX_WIDTH + 1)'(NUM_REQUESTS);

  logic [2*NUM_REQUESTS-1:0] doubled;
  logic [NUM_REQUESTS-1:0]   rotated;
  logic [INDEX_WIDTH-1:0]    rot_index;
  logic [INDEX_WIDTH:0]      sum;
  logic                      found;

  always_comb begin
    doubled   = {request_in, request_in};
    rotated   = doubled[pointer_in +: NUM_REQUESTS];
    found     = 1'b0;
    rot_index = '0;
    for (int k = 0; k < NUM_REQUESTS; k++) begin
      if (!found && rotated[k]) begin
        found     = 1'b1;
        rot_index = INDEX_WIDTH'(k);
      end
    end

    // Un-rotate: position k in the rotated view is real index (P + k) mod N.
    sum = {1'b0, rot_index} + {1'b0, pointer_in};
    if (sum >= NUM_W) begin
      sum = sum - NUM_W;
    end

    any_request_out   = found;
    winner_index_out  = found ? sum[INDEX_WIDTH-1:0] : '0;
    winner_onehot_out = found ? (NUM_REQUESTS'(1) << winner_index_out) : '0;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered valid/ready grant output. Optional
// burst ownership via lock_in is compiled in when ARB_GRANT_LOCK_EN is defined.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTS = 8,
  parameter int INDEX_WIDTH  = arb_clog2(NUM_REQUESTS)
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic [NUM_REQUESTS-1:0] request_in,
  input  logic                    grant_ready_in,
`ifdef ARB_GRANT_LOCK_EN
  input  logic                    lock_in,
`endif
  output logic                    grant_valid_out,
  output logic [NUM_REQUESTS-1:0] grant_onehot_out,
  output logic [INDEX_WIDTH-1:0]  grant_index_out,
  output logic                    state_dbg_out
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REQUESTS - 1);

  arb_state_e               state_q, state_d;
  logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [NUM_REQUESTS-1:0]  onehot_q, onehot_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;

  logic                     accept;
  logic                     hold_owner;
  logic [INDEX_WIDTH-1:0]   succ_ptr;
  logic [INDEX_WIDTH-1:0]   enc_ptr;
  logic [NUM_REQUESTS-1:0]  win_onehot;
  logic [INDEX_WIDTH-1:0]   win_index;
  logic                     win_any;

  // Handshake: a grant is presented while grant_valid_out is high and is held
  // unchanged until the cycle where grant_ready_in is also high (acceptance);
  // grant_ready_in has no effect while grant_valid_out is low.
  always_comb begin
    accept   = (state_q == ST_GRANT) && grant_ready_in;
    succ_ptr = (index_q == LAST_INDEX) ? '0 : index_q + INDEX_WIDTH'(1);
    // Arbitrating on an acceptance edge must already see the advanced pointer.
    enc_ptr  = (state_q == ST_GRANT) ? succ_ptr : ptr_q;
`ifdef ARB_GRANT_LOCK_EN
    hold_owner = accept && lock_in && |(request_in & onehot_q);
`else
    hold_owner = 1'b0;
`endif
  end

  rr_priority_encoder #(
    .NUM_REQUESTS (NUM_REQUESTS),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_encoder (
    .request_in        (request_in),
    .pointer_in        (enc_ptr),
    .winner_onehot_out (win_onehot),
    .winner_index_out  (win_index),
    .any_request_out   (win_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    onehot_d = onehot_q;
    index_d  = index_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d  = ST_GRANT;
          onehot_d = win_onehot;
          index_d  = win_index;
        end
      end
      ST_GRANT: begin
        if (accept && !hold_owner) begin
          ptr_d = succ_ptr;
          if (win_any) begin
            onehot_d = win_onehot;
            index_d  = win_index;
          end else begin
            state_d  = ST_IDLE;
            onehot_d = '0;
            index_d  = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = '0;
        index_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      onehot_q <= '0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      onehot_q <= onehot_d;
      index_q  <= index_d;
    end
  end

  assign grant_valid_out  = (state_q == ST_GRANT);
  assign grant_onehot_out = onehot_q;
  assign grant_index_out  = index_q;
  assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Testbench for round_robin_arbiter (NUM_REQUESTS=4): directed scenarios plus
// a long random run, all checked against a behavioural round-robin model.
module tb_round_robin_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 1 + IW + N;

  logic          clk_in;
  logic          reset_n_in;
  logic [N-1:0]  request_in;
  logic          grant_ready_in;
  logic          lock_in;
  logic          grant_valid_out;
  logic [N-1:0]  grant_onehot_out;
  logic [IW-1:0] grant_index_out;
  logic          state_dbg_out;

  round_robin_arbiter #(.NUM_REQUESTS(N)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .request_in       (request_in),
    .grant_ready_in   (grant_ready_in),
`ifdef ARB_GRANT_LOCK_EN
    .lock_in          (lock_in),
`endif
    .grant_valid_out  (grant_valid_out),
    .grant_onehot_out (grant_onehot_out),
    .grant_index_out  (grant_index_out),
    .state_dbg_out    (state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int m_p;
  int m_owner;
  int wait_cnt[N];
  int max_wait;

  function automatic int first_from(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_p     = 0;
    m_owner = -1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rdy, input logic lk);
    if (m_owner < 0) begin
      m_owner = first_from(req, m_p);
    end else if (rdy) begin
      for (int i = 0; i < N; i++) begin
        if (i == m_owner || !req[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      if (!(lk && req[m_owner])) begin
        m_p     = (m_owner + 1) % N;
        m_owner = first_from(req, m_p);
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [IW-1:0] idx;
    logic [N-1:0]  oh;
    idx = (m_owner >= 0) ? IW'(m_owner) : '0;
    oh  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    return {(m_owner >= 0), idx, oh};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] req, input logic rdy, input logic lk);
    @(negedge clk_in);
    request_in     = req;
    grant_ready_in = rdy;
`ifdef ARB_GRANT_LOCK_EN
    lock_in        = lk;
    model_step(req, rdy, lk);
`else
    lock_in        = 1'b0;
    model_step(req, rdy, 1'b0);
`endif
    exp_q.push_back(model_out());
  endtask

  // Asserts reset between edges and confirms outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk_in);
    #2;
    reset_n_in = 1'b0;
    #1;
    check("rst_valid", 32'(grant_valid_out), 32'd0);
    check("rst_onehot", 32'(grant_onehot_out), 32'd0);
    check("rst_index", 32'(grant_index_out), 32'd0);
    check("rst_state", 32'(state_dbg_out), 32'd0);
    model_reset();
    request_in     = '0;
    grant_ready_in = 1'b0;
    lock_in        = 1'b0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk_in) begin
    logic [W-1:0]  e;
    logic [IW-1:0] enc;
    #1;
    if (reset_n_in === 1'b1) begin
      enc = '0;
      for (int i = 0; i < N; i++) if (grant_onehot_out[i]) enc = IW'(i);
      check("onehot_le1", 32'($countones(grant_onehot_out) <= 1), 32'd1);
      check("index_encodes", 32'(grant_index_out), 32'(enc));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'({grant_valid_out, grant_index_out, grant_onehot_out}), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n_in     = 1'b0;
    request_in     = '0;
    grant_ready_in = 1'b0;
    lock_in        = 1'b0;
    max_wait       = 0;
    model_reset();

    do_reset();
    repeat (5) drive(4'b1010, 1'b1, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);

    do_reset();
    repeat (6) drive(4'b1111, 1'b1, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);

    do_reset();
    repeat (2) drive(4'b0100, 1'b0, 1'b0);
    repeat (3) drive(4'b0000, 1'b0, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);

    do_reset();
    repeat (2) drive(4'b1000, 1'b0, 1'b0);
    do_reset();
    repeat (3) drive(4'b1001, 1'b1, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);

`ifdef ARB_GRANT_LOCK_EN
    do_reset();
    repeat (4) drive(4'b0011, 1'b1, 1'b1);
    drive(4'b0011, 1'b1, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);
`endif

    do_reset();
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      drive(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0), 1'b0);
    end
    repeat (2) drive(4'b0000, 1'b1, 1'b0);
    check("starvation_bound", 32'(max_wait <= N), 32'd1);

    repeat (2) @(negedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
